serial_crc_engine: RTL and testbench

//   Parametrised bit-serial CRC generator/checker for the UART/link datapath.
//   - Absorbs one data bit per CLK while Active is high (MSB-first, left-shift Galois LFSR).
//   - Generate mode: when Active falls, shifts the CRC out serially under Out_en flow control.
//   - Check mode: the frame already carries its CRC; when Active falls, reports a zero-residue result.

---
 rtl/serial_crc_engine.sv | 169 ++++++++++++++++
 tb/tb_serial_crc_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_crc_engine.sv
// -----------------------------------------------------------------------------
// serial_crc_engine
//   Bit-serial CRC generator / checker for the UART/link datapath.
//   Frame bits are absorbed MSB-first, one per CLK while Active is high, into a
//   left-shifting Galois LFSR. When Active falls the engine either shifts the
//   CRC out serially under Out_en flow control (generate mode) or reports
//   whether the residue is zero (check mode, frame already carries its CRC).
//
// Parameters
//   CRC_WIDTH  CRC register width, 2..32
//   POLY       generator polynomial, implicit x^CRC_WIDTH term omitted
//   SEED       LFSR value at reset, on Init and at every frame start
//
// Ports
//   CLK         in  clock, rising edge
//   Reset       in  asynchronous active-low reset
//   Init        in  synchronous clear, overrides every other input
//   Data        in  serial data bit, sampled while Active=1
//   Active      in  frame-data qualifier, 1->0 ends the frame
//   Mode_check  in  sampled at frame end: 1=check, 0=generate
//   Out_en      in  downstream ready, one CRC bit per cycle with Out_en=1
//   CRC         out serial CRC bit, MSB first
//   CRC_valid   out CRC bit qualifier
//   CRC_last    out marks the final CRC bit (together with CRC_valid)
//   Busy        out high while shifting the CRC out; Active ignored then
//   Crc_done    out one-cycle pulse, check result valid
//   Crc_ok      out check result (residue zero), held until next result
// -----------------------------------------------------------------------------
module serial_crc_engine #(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLY      = 8'h07,
  parameter logic [CRC_WIDTH-1:0] SEED      = 8'h00
) (
  input  logic CLK,
  input  logic Reset,
  input  logic Init,
  input  logic Data,
  input  logic Active,
  input  logic Mode_check,
  input  logic Out_en,
  output logic CRC,
  output logic CRC_valid,
  output logic CRC_last,
  output logic Busy,
  output logic Crc_done,
  output logic Crc_ok
);

  localparam int                 CNT_W    = $clog2(CRC_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0]   CNT_INC  = CNT_W'(1'b1);
  // Emission ends on this count, so the counter can never wrap.
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CRC_WIDTH - 1);
  localparam logic [CRC_WIDTH-1:0] ZERO_W = {CRC_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // One MSB-first Galois LFSR step absorbing data bit d.
  function automatic logic [CRC_WIDTH-1:0] crc_step(
    input logic [CRC_WIDTH-1:0] lfsr,
    input logic                 d
  );
    logic fb;
    fb       = lfsr[CRC_WIDTH-1] ^ d;
    crc_step = {lfsr[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : ZERO_W);
  endfunction

  state_e                 state_q;
  logic [CRC_WIDTH-1:0]   lfsr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   crc_q;
  logic                   crc_valid_q;
  logic                   crc_last_q;
  logic                   crc_done_q;
  logic                   crc_ok_q;

  logic [CRC_WIDTH-1:0]   seed_step_d;
  logic [CRC_WIDTH-1:0]   lfsr_step_d;
  logic [CRC_WIDTH-1:0]   lfsr_shift_d;

  // Candidate next LFSR values: first bit of a frame, later bits, emit shift.
  always_comb begin
    seed_step_d  = crc_step(SEED, Data);
    lfsr_step_d  = crc_step(lfsr_q, Data);
    lfsr_shift_d = {lfsr_q[CRC_WIDTH-2:0], 1'b0};
  end

  // Frame FSM with all registered outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= SEED;
      cnt_q       <= CNT_ZERO;
      crc_q       <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_last_q  <= 1'b0;
      crc_done_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
    end else if (Init) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= SEED;
      cnt_q       <= CNT_ZERO;
      crc_q       <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_last_q  <= 1'b0;
      crc_done_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
    end else begin
      // Qualifiers and the done pulse are only high in the cycle that sets them.
      crc_valid_q <= 1'b0;
      crc_last_q  <= 1'b0;
      crc_done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Active) begin
            lfsr_q  <= seed_step_d;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (Active) begin
            lfsr_q <= lfsr_step_d;
          end else if (Mode_check) begin
            crc_ok_q   <= (lfsr_q == ZERO_W);
            crc_done_q <= 1'b1;
            lfsr_q     <= SEED;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q   <= CNT_ZERO;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Active is deliberately ignored here; Out_en=0 stalls everything.
          if (Out_en) begin
            crc_q       <= lfsr_q[CRC_WIDTH-1];
            crc_valid_q <= 1'b1;
            if (cnt_q == CNT_LAST) begin
              crc_last_q <= 1'b1;
              lfsr_q     <= SEED;
              cnt_q      <= CNT_ZERO;
              state_q    <= ST_IDLE;
            end else begin
              lfsr_q <= lfsr_shift_d;
              cnt_q  <= cnt_q + CNT_INC;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          lfsr_q  <= SEED;
          cnt_q   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign CRC       = crc_q;
  assign CRC_valid = crc_valid_q;
  assign CRC_last  = crc_last_q;
  assign Crc_done  = crc_done_q;
  assign Crc_ok    = crc_ok_q;
  assign Busy      = (state_q == ST_SEND);

endmodule

// File: tb/tb_serial_crc_engine.sv
// -----------------------------------------------------------------------------
// tb_serial_crc_engine
//   Drives an 8-bit (0x07, seed 0x00) and a 16-bit (0x1021, seed 0xFFFF)
//   engine with the same serial stimulus and compares both against a
//   polynomial long-division reference model.
// -----------------------------------------------------------------------------
module tb_serial_crc_engine;

  logic CLK, Reset, Init, Data, Active, Mode_check, Out_en;
  logic crc8, v8, l8, busy8, done8, ok8;
  logic crc16, v16, l16, busy16, done16, ok16;

  int n_assert = 0;
  int n_fail   = 0;

  bit msg_q[$];
  bit q_bit8[$], q_last8[$], q_bit16[$], q_last16[$];
  int m_busy8 = 0, m_done8 = 0, m_done16 = 0;
  int bad_oe = 0, bad_last = 0, bad_done = 0;
  logic m_ok8 = 1'b0, m_ok16 = 1'b0;
  logic done8_prev = 1'b0, done16_prev = 1'b0;
  logic oe_edge = 1'b0;
  logic [31:0] g_bits8, g_bits16;
  int g_busy8;

  serial_crc_engine #(.CRC_WIDTH(8), .POLY(8'h07), .SEED(8'h00)) u_dut8 (
    .CLK(CLK), .Reset(Reset), .Init(Init), .Data(Data), .Active(Active),
    .Mode_check(Mode_check), .Out_en(Out_en), .CRC(crc8), .CRC_valid(v8),
    .CRC_last(l8), .Busy(busy8), .Crc_done(done8), .Crc_ok(ok8));

  serial_crc_engine #(.CRC_WIDTH(16), .POLY(16'h1021), .SEED(16'hFFFF)) u_dut16 (
    .CLK(CLK), .Reset(Reset), .Init(Init), .Data(Data), .Active(Active),
    .Mode_check(Mode_check), .Out_en(Out_en), .CRC(crc16), .CRC_valid(v16),
    .CRC_last(l16), .Busy(busy16), .Crc_done(done16), .Crc_ok(ok16));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Remember Out_en as seen by each rising edge.
  always @(posedge CLK) oe_edge <= Out_en;

  // Collect emitted bits, done pulses and protocol anomalies.
  always @(negedge CLK) begin
    if (v8) begin
      q_bit8.push_back(crc8);
      q_last8.push_back(l8);
      if (!oe_edge) bad_oe <= bad_oe + 1;
    end
    if (v16) begin
      q_bit16.push_back(crc16);
      q_last16.push_back(l16);
      if (!oe_edge) bad_oe <= bad_oe + 1;
    end
    if ((l8 && !v8) || (l16 && !v16)) bad_last <= bad_last + 1;
    if (busy8) m_busy8 <= m_busy8 + 1;
    if (done8) begin
      m_done8 <= m_done8 + 1;
      m_ok8   <= ok8;
    end
    if (done16) begin
      m_done16 <= m_done16 + 1;
      m_ok16   <= ok16;
    end
    if ((done8 && done8_prev) || (done16 && done16_prev)) bad_done <= bad_done + 1;
    done8_prev  <= done8;
    done16_prev <= done16;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC as remainder of (SEED*x^n + M(x)*x^W) mod (x^W + POLY), by long division.
  function automatic logic [31:0] model_rem(input int w, input logic [31:0] poly,
                                            input logic [31:0] seed);
    int n;
    int len;
    bit a[];
    logic [31:0] r;
    n   = msg_q.size();
    len = n + w;
    a   = new[len];
    for (int j = 0; j < w; j++) a[n + j] ^= seed[j];
    for (int i = 0; i < n; i++) a[w + n - 1 - i] ^= msg_q[i];
    for (int d = len - 1; d >= w; d--) begin
      if (a[d]) begin
        a[d] = 1'b0;
        for (int j = 0; j < w; j++) a[d - w + j] ^= poly[j];
      end
    end
    r = 32'h0;
    for (int j = 0; j < w; j++) r[j] = a[j];
    return r;
  endfunction

  function automatic logic [31:0] pack(input bit q[$], input int from, input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < n; i++) r = {r[30:0], q[from + i]};
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) msg_q.push_back(b[i]);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) push_byte(s[i]);
  endtask

  // style: 0 Out_en always 1, 1 Out_en 1,0,0 pattern with Active pulses, 2 random Out_en
  task automatic run_frame(input string tag, input logic mode, input int style);
    logic [31:0] e8, e16;
    int s8, s16, sd8, sd16, sb8, n8, n16;
    bit fin;
    e8   = model_rem(8, 32'h07, 32'h0);
    e16  = model_rem(16, 32'h1021, 32'hFFFF);
    s8   = q_bit8.size();
    s16  = q_bit16.size();
    sd8  = m_done8;
    sd16 = m_done16;
    sb8  = m_busy8;
    for (int i = 0; i < msg_q.size(); i++) begin
      @(negedge CLK);
      Active = 1'b1; Data = msg_q[i]; Mode_check = mode; Out_en = 1'b1;
    end
    @(negedge CLK);
    Active = 1'b0; Data = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge CLK);
      Active = 1'b0;
      if (cyc > 0 && !busy8 && !busy16) begin
        fin = 1'b1;
        break;
      end
      if (style == 0) Out_en = 1'b1;
      else if (style == 1) Out_en = ((cyc % 3) == 0);
      else Out_en = 1'($urandom_range(0, 1));
      if (style == 1 && busy8 && busy16) Active = 1'($urandom_range(0, 1));
    end
    chk({tag, "_finish"}, 32'(fin), 32'd1);
    @(negedge CLK);
    #1;
    n8       = q_bit8.size() - s8;
    n16      = q_bit16.size() - s16;
    g_busy8  = m_busy8 - sb8;
    g_bits8  = pack(q_bit8, s8, n8);
    g_bits16 = pack(q_bit16, s16, n16);
    if (mode) begin
      chk({tag, "_done8"}, 32'(m_done8 - sd8), 32'd1);
      chk({tag, "_done16"}, 32'(m_done16 - sd16), 32'd1);
      chk({tag, "_ok8"}, 32'(m_ok8), 32'(e8 == 32'h0));
      chk({tag, "_ok16"}, 32'(m_ok16), 32'(e16 == 32'h0));
      chk({tag, "_okhold8"}, 32'(ok8), 32'(e8 == 32'h0));
      chk({tag, "_nbits"}, 32'(n8 + n16), 32'd0);
    end else begin
      chk({tag, "_nbits8"}, 32'(n8), 32'd8);
      chk({tag, "_nbits16"}, 32'(n16), 32'd16);
      chk({tag, "_crc8"}, g_bits8, e8);
      chk({tag, "_crc16"}, g_bits16, e16);
      chk({tag, "_last8"}, pack(q_last8, s8, n8), 32'd1);
      chk({tag, "_last16"}, pack(q_last16, s16, n16), 32'd1);
      chk({tag, "_nodone"}, 32'((m_done8 - sd8) + (m_done16 - sd16)), 32'd0);
    end
  endtask

  initial begin
    int s8, nb, len, pos;
    bit fin;
    Reset = 1'b0; Init = 1'b0; Data = 1'b0; Active = 1'b0;
    Mode_check = 1'b0; Out_en = 1'b0;
    #2;
    chk("reset8", 32'({crc8, v8, l8, busy8, done8, ok8}), 32'd0);
    chk("reset16", 32'({crc16, v16, l16, busy16, done16, ok16}), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b1;

    // zero-length frame: nothing happens
    repeat (4) @(negedge CLK);
    #1;
    chk("idle_quiet", 32'(q_bit8.size() + q_bit16.size() + m_done8 + m_busy8), 32'd0);

    // T1
    msg_q.delete(); push_byte(8'h80);
    run_frame("t1", 1'b0, 0);
    chk("t1_const", g_bits8, 32'h89);

    // T2
    msg_q.delete(); push_str("123456789");
    run_frame("t2", 1'b0, 0);
    chk("t2_const8", g_bits8, 32'hF4);
    chk("t6_const16", g_bits16, 32'h29B1);
    chk("t2_busy8", 32'(g_busy8), 32'd8);

    // T3 check, then a single flipped bit
    msg_q.delete(); push_byte(8'h80); push_byte(8'h89);
    run_frame("t3", 1'b1, 0);
    chk("t3_ok_const", 32'(m_ok8), 32'd1);
    pos = $urandom_range(0, 15);
    msg_q[pos] = ~msg_q[pos];
    run_frame("t3flip", 1'b1, 0);
    chk("t3flip_const", 32'(m_ok8), 32'd0);

    // T4 stalls plus Active pulses during SEND
    msg_q.delete(); push_str("123456789");
    run_frame("t4", 1'b0, 1);
    chk("t4_const8", g_bits8, 32'hF4);
    chk("t4_const16", g_bits16, 32'h29B1);

    // T6 check with the appended 16-bit CRC
    msg_q.delete(); push_str("123456789"); push_byte(8'h29); push_byte(8'hB1);
    run_frame("t6", 1'b1, 0);
    chk("t6_ok_const", 32'(m_ok16), 32'd1);

    // T5 reset mid-SEND after three bits
    msg_q.delete(); push_str("12");
    s8 = q_bit8.size();
    for (int i = 0; i < msg_q.size(); i++) begin
      @(negedge CLK);
      Active = 1'b1; Data = msg_q[i]; Mode_check = 1'b0; Out_en = 1'b1;
    end
    @(negedge CLK);
    Active = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge CLK);
      #1;
      if (q_bit8.size() - s8 >= 3) begin
        fin = 1'b1;
        break;
      end
    end
    chk("t5_reach3", 32'(fin), 32'd1);
    Reset = 1'b0;
    #1;
    chk("t5_rst8", 32'({crc8, v8, l8, busy8, done8, ok8}), 32'd0);
    chk("t5_rst16", 32'({crc16, v16, l16, busy16, done16, ok16}), 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    #1;
    s8 = q_bit8.size() + q_bit16.size();
    repeat (20) @(negedge CLK);
    #1;
    chk("t5_nopartial", 32'(q_bit8.size() + q_bit16.size() - s8), 32'd0);

    // T5 Init mid-CALC
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      Active = 1'b1; Data = 1'($urandom_range(0, 1)); Mode_check = 1'b0; Out_en = 1'b1;
    end
    @(negedge CLK);
    Active = 1'b0; Init = 1'b1;
    @(negedge CLK);
    Init = 1'b0;
    nb = m_busy8;
    s8 = q_bit8.size() + q_bit16.size();
    repeat (12) @(negedge CLK);
    #1;
    chk("t5_init_busy", 32'({busy8, busy16}), 32'd0);
    chk("t5_init_quiet", 32'(q_bit8.size() + q_bit16.size() - s8 + m_busy8 - nb), 32'd0);

    msg_q.delete(); push_byte(8'h80);
    run_frame("t5_t1", 1'b0, 0);
    chk("t5_t1_const", g_bits8, 32'h89);

    // one-bit frame
    msg_q.delete(); msg_q.push_back(1'b1);
    run_frame("onebit", 1'b0, 2);

    // random frames
    for (int k = 0; k < 8; k++) begin
      msg_q.delete();
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) msg_q.push_back(1'($urandom_range(0, 1)));
      run_frame($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), $urandom_range(1, 2));
    end

    chk("valid_without_oe", 32'(bad_oe), 32'd0);
    chk("last_without_valid", 32'(bad_last), 32'd0);
    chk("done_pulse_width", 32'(bad_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
